// File: rtl/magnetron_ctrl.sv
// magnetron_ctrl: microwave magnetron sequencer (IDLE/RUN/PAUSE/DONE) with framed duty-cycle drive.
// Optional door debounce filter: define MAGNETRON_DOOR_DEBOUNCE_EN. Rev 1.0
`default_nettype none

module magnetron_ctrl #(
   parameter int POWER_W         = 3,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               startn,
   input  logic               stopn,
   input  logic               clearn,
   input  logic               door_closed,
   input  logic               timer_done,
   input  logic               tick,
   input  logic [POWER_W-1:0] power_level,
   output logic               mag_on,
   output logic [1:0]         state,
   output logic               done_pulse
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   state_t             state_q, state_d;
   logic [POWER_W-1:0] cnt_q, cnt_d;
   logic [POWER_W-1:0] duty_q, duty_d;
   logic               mag_on_q, mag_on_d;
   logic               done_pulse_q, done_pulse_d;
   logic               door_ok;

`ifdef MAGNETRON_DOOR_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic            filt_q, filt_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;

   // Filtered door flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      filt_d   = filt_q;
      db_cnt_d = '0;
      if (door_closed != filt_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            filt_d = door_closed;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         filt_q   <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         filt_q   <= filt_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   assign door_ok = filt_q;
`else
   if (DEBOUNCE_CYCLES < 1) begin : g_no_filter
   end
   assign door_ok = door_closed;
`endif

   // Highest-priority active event wins, even when it has no effect in the current state.
   always_comb begin
      state_d = state_q;
      if (!clearn) begin
         state_d = IDLE;
      end else if (!door_ok) begin
         if (state_q == RUN)       state_d = PAUSE;
         else if (state_q == DONE) state_d = IDLE;
      end else if (!stopn) begin
         if (state_q == RUN)        state_d = PAUSE;
         else if (state_q == PAUSE) state_d = IDLE;
      end else if (timer_done && (state_q == RUN)) begin
         state_d = DONE;
      end else if (!startn) begin
         if ((state_q == IDLE) || (state_q == PAUSE)) state_d = RUN;
      end
   end

   always_comb begin
      cnt_d  = cnt_q;
      duty_d = duty_q;
      if ((state_d == RUN) && (state_q != RUN)) begin
         cnt_d  = '0;
         duty_d = power_level;
      end else if ((state_d == RUN) && tick) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == '1) begin
            duty_d = power_level;
         end
      end
      mag_on_d     = (state_d == RUN) && ((&duty_d) || (cnt_d < duty_d));
      done_pulse_d = (state_d == DONE) && (state_q != DONE);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         duty_q       <= '0;
         mag_on_q     <= 1'b0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         duty_q       <= duty_d;
         mag_on_q     <= mag_on_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   assign state      = state_q;
   assign mag_on     = mag_on_q;
   assign done_pulse = done_pulse_q;

endmodule

`default_nettype wire

// File: tb/tb_magnetron_ctrl.sv
// tb_magnetron_ctrl: directed-vector bench for magnetron_ctrl.
`default_nettype none

module tb_magnetron_ctrl;

   localparam int POWER_W = 3;
   localparam int DB      = 4;
`ifdef MAGNETRON_DOOR_DEBOUNCE_EN
   localparam int DL = DB + 1;
`else
   localparam int DL = 1;
`endif

   logic               clock = 1'b0;
   logic               resetn, startn, stopn, clearn, door_closed, timer_done, tick;
   logic [POWER_W-1:0] power_level;
   logic               mag_on, done_pulse;
   logic [1:0]         state;

   int n_vec  = 0;
   int n_fail = 0;

   magnetron_ctrl #(.POWER_W(POWER_W), .DEBOUNCE_CYCLES(DB)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .startn      (startn),
      .stopn       (stopn),
      .clearn      (clearn),
      .door_closed (door_closed),
      .timer_done  (timer_done),
      .tick        (tick),
      .power_level (power_level),
      .mag_on      (mag_on),
      .state       (state),
      .done_pulse  (done_pulse)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Door change becomes visible to the FSM on the next step() after this returns.
   task automatic set_door(input logic v);
      door_closed = v;
      repeat (DL - 1) step();
   endtask

   task automatic pulse_start();
      startn = 1'b0;
      step();
      startn = 1'b1;
   endtask

   initial begin
      resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
      door_closed = 1'b1; timer_done = 1'b0; tick = 1'b0; power_level = 3'd7;
      step(); step();
      chk("rst_state", 8'(state), 8'h0);
      chk("rst_mag", 8'(mag_on), 8'h0);
      chk("rst_done", 8'(done_pulse), 8'h0);

      resetn = 1'b1;
      repeat (DL) step();
      chk("idle_hold", 8'(state), 8'h0);

      // Full power: continuous drive over 3 frames
      pulse_start();
      chk("p7_state", 8'(state), 8'h1);
      chk("p7_mag0", 8'(mag_on), 8'h1);
      tick = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         step();
         chk("p7_mag", 8'(mag_on), 8'h1);
      end
      tick = 1'b0;

      // stop -> PAUSE
      stopn = 1'b0; step(); stopn = 1'b1;
      chk("stop_state", 8'(state), 8'h2);
      chk("stop_mag", 8'(mag_on), 8'h0);

      // power 3, mid-frame change to 5 only applies from next frame
      power_level = 3'd3;
      pulse_start();
      chk("p3_state", 8'(state), 8'h1);
      chk("p3_pos0", 8'(mag_on), 8'h1);
      tick = 1'b1;
      for (int i = 1; i < 16; i++) begin
         step();
         if (i < 8) chk("p3_frame0", 8'(mag_on), (i < 3) ? 8'h1 : 8'h0);
         else       chk("p3_frame1", 8'(mag_on), ((i - 8) < 5) ? 8'h1 : 8'h0);
         if (i == 4) power_level = 3'd5;
      end
      tick = 1'b0;

      // stop beats timer_done; restart resets counter
      stopn = 1'b0; timer_done = 1'b1; step(); stopn = 1'b1; timer_done = 1'b0;
      chk("stoptmr_state", 8'(state), 8'h2);
      chk("stoptmr_done", 8'(done_pulse), 8'h0);
      pulse_start();
      chk("restart_state", 8'(state), 8'h1);
      chk("restart_pos0", 8'(mag_on), 8'h1);
      tick = 1'b1;
      repeat (4) step();
      chk("restart_pos4", 8'(mag_on), 8'h1);
      step();
      chk("restart_pos5", 8'(mag_on), 8'h0);
      tick = 1'b0;

      // timer_done -> DONE
      timer_done = 1'b1; step(); timer_done = 1'b0;
      chk("done_state", 8'(state), 8'h3);
      chk("done_pulse1", 8'(done_pulse), 8'h1);
      chk("done_mag", 8'(mag_on), 8'h0);
      step();
      chk("done_pulse2", 8'(done_pulse), 8'h0);
      pulse_start();
      chk("done_ign_start", 8'(state), 8'h3);
      set_door(1'b0); step();
      chk("done_door", 8'(state), 8'h0);
      set_door(1'b1); step();

      // clear beats door-open
      power_level = 3'd7;
      pulse_start();
      chk("clr_run", 8'(state), 8'h1);
      clearn = 1'b0; door_closed = 1'b0; step(); clearn = 1'b1;
      chk("clr_state", 8'(state), 8'h0);
      chk("clr_mag", 8'(mag_on), 8'h0);

      // door open in IDLE blocks start
      set_door(1'b0);
      pulse_start();
      chk("idle_door_open", 8'(state), 8'h0);
      set_door(1'b1); step();

      // reset mid-RUN, then first start right after release
      pulse_start();
      chk("rr_run", 8'(state), 8'h1);
      resetn = 1'b0; startn = 1'b0; step(); startn = 1'b1;
      chk("rr_state", 8'(state), 8'h0);
      chk("rr_mag", 8'(mag_on), 8'h0);
      resetn = 1'b1;
      repeat (DL - 1) step();
      pulse_start();
      chk("rr_first", 8'(state), 8'h1);

      // zero power: never drives
      stopn = 1'b0; step(); stopn = 1'b1;
      power_level = 3'd0;
      pulse_start();
      chk("p0_state", 8'(state), 8'h1);
      chk("p0_mag0", 8'(mag_on), 8'h0);
      tick = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         chk("p0_mag", 8'(mag_on), 8'h0);
      end
      tick = 1'b0;

      // stop in PAUSE -> IDLE
      stopn = 1'b0; step();
      chk("p_stop1", 8'(state), 8'h2);
      step(); stopn = 1'b1;
      chk("p_stop2", 8'(state), 8'h0);

`ifdef MAGNETRON_DOOR_DEBOUNCE_EN
      power_level = 3'd7;
      pulse_start();
      door_closed = 1'b0;
      repeat (3) step();
      door_closed = 1'b1;
      repeat (3) step();
      chk("glitch3", 8'(state), 8'h1);
      door_closed = 1'b0;
      repeat (4) step();
      chk("open4_pre", 8'(state), 8'h1);
      step();
      chk("open4", 8'(state), 8'h2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/magnetron_ctrl.md
MAGNETRON_CTRL -- requirements
Module: magnetron_ctrl

Interface
REQ-001 Parameter POWER_W, default 3: width of power_level; the duty frame is 2**POWER_W ticks long.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: number of stable clocks the door filter needs, used only with the REQ-030 macro.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 startn  in  1  start request, active-low, level-sampled.
REQ-006 stopn  in  1  stop/pause request, active-low.
REQ-007 clearn  in  1  clear request, active-low.
REQ-008 door_closed  in  1  1 = door closed.
REQ-009 timer_done  in  1  cook timer expired, active-high.
REQ-010 tick  in  1  one-clock duty-frame advance strobe.
REQ-011 power_level  in  POWER_W  requested duty: 0 = off, all-ones = continuous.
REQ-012 mag_on  out  1  magnetron drive, registered.
REQ-013 state  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-014 done_pulse  out  1  one-clock pulse on entry to DONE.

Function
REQ-015 The FSM SHALL evaluate events each clock in priority order: clearn low > door open > stopn low > timer_done high > startn low.
REQ-016 clearn low SHALL force IDLE from any state on the next clock.
REQ-017 IDLE: startn low with door closed -> RUN; startn low with door open -> stay in IDLE.
REQ-018 RUN: door open -> PAUSE; stopn low -> PAUSE; timer_done high -> DONE.
REQ-019 PAUSE: stopn low -> IDLE; startn low with door closed -> RUN; otherwise hold.
REQ-020 DONE: door open -> IDLE; all other events except clearn are ignored.
REQ-021 timer_done SHALL be ignored outside RUN.
REQ-022 A POWER_W-bit frame counter SHALL load 0 on every entry to RUN and increment, wrapping from 2**POWER_W-1 to 0, on each tick while in RUN; it SHALL hold in every other state.
REQ-023 duty_reg SHALL capture power_level on entry to RUN and whenever the counter wraps to 0; power_level changes mid-frame SHALL NOT take effect until the next frame.
REQ-024 mag_on SHALL be registered and equal (next state == RUN) and (duty_reg all-ones, or frame counter < duty_reg), so that it rises on the same edge the FSM enters RUN.
REQ-025 With duty_reg = 0, mag_on SHALL stay 0 for the whole of RUN; with all-ones it SHALL stay 1 for the whole of RUN.
REQ-026 mag_on SHALL fall on the same clock edge on which the FSM leaves RUN for any reason.
REQ-027 done_pulse SHALL be high for exactly one clock, the clock edge at which state becomes DONE.

Reset
REQ-028 resetn low at a clock edge SHALL set state=IDLE, mag_on=0, done_pulse=0, frame counter=0 and duty_reg=0; this overrides all other inputs, including mid-RUN.
REQ-029 The first transition SHALL be possible on the first edge at which resetn is high.

Configuration
REQ-030 With MAGNETRON_DOOR_DEBOUNCE_EN defined, the filtered door value SHALL change only after door_closed has differed from it for DEBOUNCE_CYCLES consecutive clocks; it resets to 0 (open) and the FSM uses only the filtered value.
REQ-031 Without MAGNETRON_DOOR_DEBOUNCE_EN, the FSM SHALL use door_closed directly, with no filter logic present.

Verification
REQ-032 Reset, door_closed=1, power_level=7, startn low 1 clk -> state=01, mag_on=1 continuously for 3 frames.
REQ-033 power_level=3, run 16 ticks -> mag_on high for ticks 0-2 and low for ticks 3-7 of each frame; change to 5 at tick 4 takes effect at tick 8.
REQ-034 In RUN, stopn and timer_done both low/high in the same clock -> state=10, no done_pulse; then startn low -> state=01, counter restarts at 0.
REQ-035 In RUN, timer_done=1 -> state=11, done_pulse for 1 clk, mag_on=0; startn ignored; door_closed=0 -> state=00.
REQ-036 In RUN, door_closed=0 together with clearn=0 -> state=00 (clear wins), mag_on=0 on the same edge.
REQ-037 With the macro defined and DEBOUNCE_CYCLES=4: a 3-clock door-open glitch during RUN -> no state change; a 4-clock open -> state=10.
